// File: rtl/pulse_period_meter_pkg.sv
// Shared types and helpers for the pulse period meter and its tick consumers.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  // Bits needed to hold a run counter that saturates at lock_count.
  function automatic int lock_cnt_width(input int lock_count);
    return (lock_count < 1) ? 1 : $clog2(lock_count + 1);
  endfunction

endpackage

// File: rtl/pulse_period_meter_if.sv
// Measured pulse input and the measurement results of a pulse period meter.
interface pulse_period_meter_if #(
  parameter int CNT_WIDTH = 24
);
  logic                 pulse_in;
  logic [CNT_WIDTH-1:0] period;
  logic                 period_valid;
  logic                 in_range;
  logic                 timeout;
  logic                 locked;

  modport master (
    output pulse_in,
    input  period, period_valid, in_range, timeout, locked
  );

  modport slave (
    input  pulse_in,
    output period, period_valid, in_range, timeout, locked
  );
endinterface

// File: rtl/pulse_period_meter_edge_sync.sv
// Optional synchronizer chain plus a delay flop, producing a one-cycle pulse
// on each rising edge of the (synchronized) input.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s;
  logic prev;

  if (SYNC_STAGES == 0) begin : g_direct
    assign s = d;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    // NOTE: reset is synchronous, so it sits inside the clocked block and is
    // not in the sensitivity list.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= d;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= s;
  end

  assign rise = s & ~prev;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures clk cycles between rising edges of pulse_in, flags out-of-tolerance
// periods and missing pulses, and declares lock after a run of good periods.
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_WIDTH     = 24,
  parameter int SYNC_STAGES   = 2,
  parameter int EXPECT_PERIOD = 5,
  parameter int TOLERANCE     = 0,
  parameter int MAX_PERIOD    = 1000,
  parameter int LOCK_COUNT    = 4
) (
  input logic                 clk,
  input logic                 rst,
  pulse_period_meter_if.slave mif
);

  if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("pulse_period_meter: SYNC_STAGES must be 0..3");
  end
  if (EXPECT_PERIOD < 2 || LOCK_COUNT < 1 || EXPECT_PERIOD + TOLERANCE >= MAX_PERIOD) begin : g_bad_cfg
    $error("pulse_period_meter: inconsistent period/lock parameters");
  end

  localparam int                   LOCK_W   = lock_cnt_width(LOCK_COUNT);
  localparam logic [LOCK_W-1:0]    LOCK_MAX = LOCK_W'(LOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(MAX_PERIOD);
  localparam logic [CNT_WIDTH:0]   EXP_EXT  = (CNT_WIDTH + 1)'(EXPECT_PERIOD);
  localparam logic [CNT_WIDTH:0]   TOL_EXT  = (CNT_WIDTH + 1)'(TOLERANCE);

  logic                 rise;
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] period_q;
  logic [LOCK_W-1:0]    lock_cnt;
  logic                 period_valid_q;
  logic                 in_range_q;
  logic                 timeout_q;
  logic                 locked_q;

  logic [CNT_WIDTH:0]   cnt_ext;
  logic [CNT_WIDTH:0]   diff;
  logic                 cnt_in_range;
  logic [LOCK_W-1:0]    lock_inc;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk (clk),
    .rst (rst),
    .d   (mif.pulse_in),
    .rise(rise)
  );

  // The extra bit keeps the unsigned difference exact in both directions.
  // NOTE: every always_comb output gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    cnt_ext = {1'b0, cnt};
    diff    = (cnt_ext >= EXP_EXT) ? (cnt_ext - EXP_EXT) : (EXP_EXT - cnt_ext);
  end

  assign cnt_in_range = (diff <= TOL_EXT);
  assign lock_inc     = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + LOCK_W'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      in_range_q     <= 1'b0;
      timeout_q      <= 1'b0;
      locked_q       <= 1'b0;
      lock_cnt       <= '0;
    end else begin
      period_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= MEASURE;
            cnt   <= CNT_WIDTH'(1);
          end
        end

        MEASURE: begin
          // An edge landing on cnt == MAX_CNT is still a valid measurement.
          if (rise) begin
            period_q       <= cnt;
            period_valid_q <= 1'b1;
            in_range_q     <= cnt_in_range;
            cnt            <= CNT_WIDTH'(1);
            if (cnt_in_range) begin
              lock_cnt <= lock_inc;
              locked_q <= (lock_inc == LOCK_MAX);
            end else begin
              lock_cnt <= '0;
              locked_q <= 1'b0;
            end
          end else if (cnt == MAX_CNT) begin
            state     <= TIMEOUT;
            timeout_q <= 1'b1;
            locked_q  <= 1'b0;
            lock_cnt  <= '0;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end

        TIMEOUT: begin
          // The re-arming edge closes an unbounded gap, so it is not reported.
          if (rise) begin
            state     <= MEASURE;
            cnt       <= CNT_WIDTH'(1);
            timeout_q <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign mif.period       = period_q;
  assign mif.period_valid = period_valid_q;
  assign mif.in_range     = in_range_q;
  assign mif.timeout      = timeout_q;
  assign mif.locked       = locked_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed and randomized pulse trains against an edge-timestamp reference
// model; every cycle compares all outputs with the model.
module tb_pulse_period_meter;

  localparam int CNT_WIDTH     = 24;
  localparam int SYNC_STAGES   = 2;
  localparam int EXPECT_PERIOD = 5;
  localparam int TOLERANCE     = 0;
  localparam int MAX_PERIOD    = 20;
  localparam int LOCK_COUNT    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pulse_period_meter_if #(.CNT_WIDTH(CNT_WIDTH)) mif ();

  pulse_period_meter #(
    .CNT_WIDTH    (CNT_WIDTH),
    .SYNC_STAGES  (SYNC_STAGES),
    .EXPECT_PERIOD(EXPECT_PERIOD),
    .TOLERANCE    (TOLERANCE),
    .MAX_PERIOD   (MAX_PERIOD),
    .LOCK_COUNT   (LOCK_COUNT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mif(mif)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: edge timestamps in clk cycles, delayed by the fixed
  // input latency of the synchronizer chain.
  bit pend[$];
  bit prev_p;
  bit armed;
  int edge_no;
  int last_edge;
  int run;
  int m_period;
  bit m_valid, m_in_range, m_timeout, m_locked;

  // Values observed on the most recent strobe, for directed checks.
  int strobes;
  int last_period;
  bit last_in_range, last_locked;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit p, input bit r);
    bit in_rise, rise_eff;
    int gap, dev;
    edge_no++;
    m_valid = 1'b0;
    if (r) begin
      pend.delete();
      for (int i = 0; i < SYNC_STAGES; i++) pend.push_back(1'b0);
      prev_p = 1'b0; armed = 1'b0; run = 0;
      m_period = 0; m_in_range = 1'b0; m_timeout = 1'b0; m_locked = 1'b0;
      return;
    end
    in_rise = p && !prev_p;
    prev_p  = p;
    pend.push_back(in_rise);
    rise_eff = pend.pop_front();
    if (!armed) begin
      if (rise_eff) begin
        armed = 1'b1; last_edge = edge_no; m_timeout = 1'b0;
      end
    end else begin
      gap = edge_no - last_edge;
      if (rise_eff) begin
        dev        = (gap >= EXPECT_PERIOD) ? gap - EXPECT_PERIOD : EXPECT_PERIOD - gap;
        m_period   = gap;
        m_valid    = 1'b1;
        m_in_range = (dev <= TOLERANCE);
        if (m_in_range) begin
          if (run < LOCK_COUNT) run++;
          m_locked = (run == LOCK_COUNT);
        end else begin
          run = 0; m_locked = 1'b0;
        end
        last_edge = edge_no;
      end else if (gap == MAX_PERIOD) begin
        m_timeout = 1'b1; m_locked = 1'b0; run = 0; armed = 1'b0;
      end
    end
  endtask

  task automatic step(input bit p, input bit r);
    mif.pulse_in = p;
    rst          = r;
    @(posedge clk);
    model_update(p, r);
    @(negedge clk);
    check("period",       32'(mif.period),       32'(m_period));
    check("period_valid", 32'(mif.period_valid), 32'(m_valid));
    check("in_range",     32'(mif.in_range),     32'(m_in_range));
    check("timeout",      32'(mif.timeout),      32'(m_timeout));
    check("locked",       32'(mif.locked),       32'(m_locked));
    if (mif.period_valid === 1'b1) begin
      strobes++;
      last_period   = int'(mif.period);
      last_in_range = mif.in_range;
      last_locked   = mif.locked;
    end
  endtask

  task automatic pulse(input int gap, input int high);
    for (int i = 0; i < gap; i++) step(i < high, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  initial begin
    int s0, gap, high;
    mif.pulse_in = 1'b0;
    for (int i = 0; i < SYNC_STAGES; i++) pend.push_back(1'b0);

    repeat (3) step(1'b0, 1'b1);
    check("reset_period", 32'(mif.period), 32'd0);

    // Steady period 5: lock on the 4th strobe.
    repeat (6) pulse(5, 1);
    check("steady_period", 32'(last_period), 32'd5);
    check("steady_locked", 32'(last_locked), 32'd1);

    // One period of 7 drops lock on its strobe; four periods of 5 relock.
    pulse(7, 1);
    pulse(5, 1);
    check("gap7_period",   32'(last_period),   32'd7);
    check("gap7_in_range", 32'(last_in_range), 32'd0);
    check("gap7_locked",   32'(last_locked),   32'd0);
    repeat (4) pulse(5, 1);
    check("relock_locked", 32'(last_locked), 32'd1);

    // Pulses stop: timeout, then re-arm without a strobe, then measure.
    idle(25);
    check("timeout_level",  32'(mif.timeout), 32'd1);
    check("timeout_locked", 32'(mif.locked),  32'd0);
    s0 = strobes;
    pulse(5, 1);
    check("rearm_no_strobe", 32'(strobes - s0), 32'd0);
    pulse(5, 1);
    check("rearm_period", 32'(last_period), 32'd5);

    // Edge exactly at MAX_PERIOD is a measurement, not a timeout.
    repeat (3) pulse(20, 1);
    check("max_period", 32'(last_period), 32'd20);
    check("max_no_timeout", 32'(mif.timeout), 32'd0);

    // Wide high level is counted once per rising edge.
    repeat (4) pulse(10, 3);
    check("wide_period", 32'(last_period), 32'd10);

    // Reset mid-period, then re-arm and measure.
    pulse(4, 3);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("midreset_period", 32'(mif.period), 32'd0);
    s0 = strobes;
    pulse(6, 1);
    check("post_reset_no_strobe", 32'(strobes - s0), 32'd0);
    repeat (2) pulse(6, 1);
    check("post_reset_period", 32'(last_period), 32'd6);

    // pulse_in held high through reset yields one arming edge afterwards.
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    idle(3);
    repeat (3) pulse(8, 2);

    // Randomized trains, including gaps beyond MAX_PERIOD and rare resets.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 7) gap = int'($urandom_range(4, 6));
      else                          gap = int'($urandom_range(15, 25));
      high = int'($urandom_range(1, gap - 1));
      pulse(gap, high);
      if ($urandom_range(0, 24) == 0) begin
        step(1'($urandom_range(0, 1)), 1'b1);
        step(1'($urandom_range(0, 1)), 1'b1);
      end
    end
    idle(25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
